// File: rtl/ef_i2s_pkg.sv
// ============================================================================
//  Module      : ef_i2s_pkg
//  Description : Shared constants and helpers for the EF I2S/TDM receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ef_i2s_pkg;

    localparam int   c_slot_w        = 32;
    localparam logic c_ws_mode_duty  = 1'b0;
    localparam logic c_ws_mode_pulse = 1'b1;

    // Minimum number of bits able to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ef_util_fifo.sv
// ============================================================================
//  Module      : ef_util_fifo
//  Description : Synchronous FIFO, 2^AW entries, single-cycle flush,
//                combinational head read-out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ef_util_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full,
    output logic [AW-1:0] level
);

    localparam int c_depth = 1 << AW;

    logic [DW-1:0] r_mem [c_depth];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_wr;
    logic          w_do_rd;

    assign w_do_wr = wr && !full;
    assign w_do_rd = rd && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + 1'b1;
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !flush) r_mem[r_wptr] <= wdata;
    end

    // Level wraps to 0 when full; 'full' disambiguates that case.
    assign rdata = r_mem[r_rptr];
    assign empty = (r_count == '0);
    assign full  = r_count[AW];
    assign level = r_count[AW-1:0];

endmodule

`default_nettype wire

// File: rtl/ef_i2s_tdm.sv
// ============================================================================
//  Module      : ef_i2s_tdm
//  Description : I2S/TDM master receiver: SCK/WS generation, slot capture,
//                formatting and FIFO. Optional per-slot peak meters are
//                enabled by defining EF_I2S_TDM_PEAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ef_i2s_tdm
    import ef_i2s_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  ws_mode,
    input  logic                  left_justified,
    input  logic [7:0]            sck_prescaler,
    input  logic [5:0]            sample_size,
    input  logic                  sign_extend,
    input  logic [NCH-1:0]        ch_mask,
    output logic                  sck,
    output logic                  ws,
    input  logic                  sdi,
    input  logic                  fifo_rd,
    input  logic                  fifo_flush,
    input  logic [AW-1:0]         fifo_threshold,
    output logic [31:0]           fifo_rdata,
    output logic [clog2(NCH)-1:0] fifo_rch,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_above,
    output logic [AW-1:0]         fifo_level,
    input  logic                  ovr_clr,
    output logic                  ovr
`ifdef EF_I2S_TDM_PEAK_EN
    ,
    input  logic [clog2(NCH)-1:0] peak_sel,
    input  logic                  peak_clr,
    output logic [31:0]           peak_value
`endif
);

    localparam int CW = clog2(NCH);
    localparam int NB = NCH * c_slot_w;
    localparam int BW = clog2(NB);
    localparam int DW = c_slot_w + CW;

    logic [7:0]    r_presc;
    logic          r_sck;
    logic          r_ws;
    logic [BW-1:0] r_bit;
    logic [31:0]   r_sr;
    logic          r_first;
    logic          r_cap;
    logic [CW-1:0] r_cap_ch;
    logic          r_ovr;

    logic [BW-1:0] w_bit_m;
    logic [BW-1:0] w_bit_nxt;
    logic          w_ws_nxt;
    logic          w_lsb_hit;
    logic [CW-1:0] w_slot;
    logic [4:0]    w_shamt;
    logic [31:0]   w_data;
    logic          w_push_req;
    logic          w_wr;
    logic          w_ovr_set;
    logic [DW-1:0] w_rdata;

    // Position within the data stream, i.e. frame bit index minus data delay.
    always_comb begin
        w_bit_m = r_bit;
        if (!left_justified) begin
            w_bit_m = (r_bit == '0) ? BW'(NB - 1) : r_bit - 1'b1;
        end
    end

    assign w_lsb_hit = &w_bit_m[4:0];
    assign w_slot    = w_bit_m[BW-1:5];
    assign w_bit_nxt = (r_bit == BW'(NB - 1)) ? '0 : r_bit + 1'b1;
    assign w_ws_nxt  = (ws_mode == c_ws_mode_pulse) ? (w_bit_nxt == '0)
                                                    : (w_bit_nxt >= BW'(NB / 2));

    // r_first marks b=0 of the first frame after enable, where the delayed
    // last slot would straddle the restart and must not be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc  <= '0;
            r_sck    <= 1'b0;
            r_ws     <= 1'b1;
            r_bit    <= '0;
            r_sr     <= '0;
            r_first  <= 1'b1;
            r_cap    <= 1'b0;
            r_cap_ch <= '0;
        end else if (!en) begin
            r_presc  <= '0;
            r_sck    <= 1'b0;
            r_ws     <= (ws_mode == c_ws_mode_duty);
            r_bit    <= '0;
            r_sr     <= '0;
            r_first  <= 1'b1;
            r_cap    <= 1'b0;
        end else begin
            r_cap <= 1'b0;
            if (r_presc == 8'd0) begin
                r_presc <= sck_prescaler;
                r_sck   <= ~r_sck;
                if (!r_sck) begin
                    r_sr <= {r_sr[30:0], sdi};
                    if (w_lsb_hit && !r_first) begin
                        r_cap    <= 1'b1;
                        r_cap_ch <= w_slot;
                    end
                end else begin
                    r_bit   <= w_bit_nxt;
                    r_ws    <= w_ws_nxt;
                    r_first <= 1'b0;
                end
            end else begin
                r_presc <= r_presc - 8'd1;
            end
        end
    end

    always_comb begin
        w_shamt = 5'd0;
        if (sample_size != 6'd0 && sample_size < 6'd32) begin
            w_shamt = 5'(6'd32 - sample_size);
        end
    end

    // data[S-1] is always sr[31], so it drives the extension directly.
    assign w_data = (r_sr >> w_shamt)
                  | ((sign_extend && r_sr[31]) ? ~(32'hFFFF_FFFF >> w_shamt) : 32'h0);

    assign w_push_req = r_cap && ch_mask[r_cap_ch];
    assign w_wr       = w_push_req && !fifo_full && !fifo_flush;
    assign w_ovr_set  = w_push_req && fifo_full && !fifo_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_ovr <= 1'b0;
        else if (w_ovr_set)  r_ovr <= 1'b1;
        else if (ovr_clr)    r_ovr <= 1'b0;
    end

    ef_util_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .wr    (w_wr),
        .wdata ({r_cap_ch, w_data}),
        .rd    (fifo_rd),
        .rdata (w_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign fifo_rdata = w_rdata[31:0];
    assign fifo_rch   = w_rdata[c_slot_w +: CW];
    assign fifo_above = (fifo_level > fifo_threshold) | fifo_full;
    assign sck        = r_sck;
    assign ws         = r_ws;
    assign ovr        = r_ovr;

`ifdef EF_I2S_TDM_PEAK_EN
    logic [31:0] r_peak [NCH];
    logic [31:0] w_mag;

    assign w_mag = (sign_extend && w_data[31]) ? ~w_data : w_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) r_peak[i] <= '0;
        end else if (peak_clr) begin
            for (int i = 0; i < NCH; i++) r_peak[i] <= '0;
        end else if (w_push_req && (w_mag > r_peak[r_cap_ch])) begin
            r_peak[r_cap_ch] <= w_mag;
        end
    end

    assign peak_value = (int'(peak_sel) < NCH) ? r_peak[peak_sel] : 32'h0;
`endif

endmodule

`default_nettype wire

// File: doc/ef_i2s_tdm.md
EF_I2S_TDM -- requirements
Module: EF_I2S_TDM

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of 32-bit TDM slots per frame (legal 2..8, even).
REQ-002 SHALL have parameter AW, default 4, meaning the FIFO depth is 2^AW entries.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst_n` (in, 1, asynchronous active-low reset).
REQ-004 SHALL have the following control inputs:
- `en` (in, 1): block enable.
- `ws_mode` (in, 1): 0 = 50% duty WS; 1 = one-SCK frame pulse.
- `left_justified` (in, 1): 0 = 1-bit delay; 1 = no delay.
REQ-005 SHALL have the following data-format inputs:
- `sck_prescaler` (in, 8): SCK half-period minus 1, in clk cycles.
- `sample_size` (in, 6): valid MSBs per slot; 0 = 32.
- `sign_extend` (in, 1): enable sign extension.
- `ch_mask` (in, NCH): per-slot capture enable.
REQ-006 SHALL have the following serial-bus ports: `sck` (out, 1), `ws` (out, 1), `sdi` (in, 1).
REQ-007 SHALL have the following FIFO ports:
- `fifo_rd`, `fifo_flush` (in, 1 each).
- `fifo_threshold` (in, AW).
- `fifo_rdata` (out, 32).
- `fifo_rch` (out, clog2(NCH)): slot index of the head entry.
- `fifo_empty`, `fifo_full`, `fifo_above` (out, 1 each).
- `fifo_level` (out, AW).
REQ-008 SHALL have ports `ovr_clr` (in, 1) and `ovr` (out, 1, sticky overrun).

Function
REQ-009 SHALL drive `sck` as follows:
- The prescaler counter decrements each clk while `en`=1.
- At 0 it reloads `sck_prescaler` and toggles `sck`.
- `sck` period is 2*(`sck_prescaler`+1) clk cycles.
REQ-010 SHALL count the frame bit index b (0..NCH*32-1) on each SCK falling toggle, wrapping to 0 after NCH*32-1.
REQ-011 SHALL drive `ws` per `ws_mode`:
- `ws_mode`=0: `ws` is 0 for b < NCH*16, else 1.
- `ws_mode`=1: `ws` is 1 only for b=0.
- `ws` changes only on SCK falling toggles.
REQ-012 SHALL sample `sdi` on each SCK rising toggle into a 32-bit shift register, MSB first.
REQ-013 SHALL use data delay d = 0 when `left_justified`=1 and d = 1 otherwise.
REQ-014 SHALL treat slot k data as occupying bits k*32+d .. k*32+31+d (modulo frame length), so for d=1 the last slot completes at b=0 of the next frame.
REQ-015 SHALL raise capture for slot k for exactly one clk, the cycle after the rising toggle that samples the slot's LSB.
REQ-016 SHALL format captured data as data = sr >> (32-S), where S = `sample_size` (0 treated as 32).
REQ-017 SHALL, when `sign_extend`=1, fill bits [31:S] with data[S-1].
REQ-018 SHALL push {k, data} into the FIFO on capture only when `ch_mask`[k]=1 and `fifo_full`=0.
REQ-019 SHALL, on capture with `ch_mask`[k]=1 and `fifo_full`=1, drop the sample, leave FIFO contents unchanged and set `ovr`.
REQ-020 SHALL clear `ovr` on `ovr_clr`; if `ovr_clr` and a set condition coincide, `ovr` SHALL remain 1.
REQ-021 SHALL apply `fifo_rd` only when the FIFO is not empty.
REQ-022 SHALL, on simultaneous push and pop while full, perform the pop and treat the push as an overrun.
REQ-023 SHALL, on `fifo_flush`, empty the FIFO in one clk; a push in the same cycle SHALL be discarded and SHALL NOT set `ovr`.
REQ-024 SHALL drive `fifo_above` = (`fifo_level` > `fifo_threshold`) | `fifo_full`.
REQ-025 SHALL present `fifo_rdata` and `fifo_rch` from the head entry combinationally; both are don't-care while `fifo_empty`=1.
REQ-026 SHALL, when `en`=0:
- hold the prescaler at 0, b at 0 and `sck` at 0;
- hold `ws` at 1 for `ws_mode`=0 and at 0 for `ws_mode`=1;
- clear the shift register;
- retain FIFO contents and `ovr`.
REQ-027 SHALL, when `en` rises, start a new frame at b=0 and suppress capture of a partial slot straddling the previous disable.
REQ-028 SHALL, for d=1, produce no slot NCH-1 capture in the first frame after enable.

Reset
REQ-029 SHALL on `rst_n`=0 asynchronously set `sck`=0, `ws`=1, prescaler=0, b=0, shift register=0, `ovr`=0, FIFO empty (`fifo_empty`=1, `fifo_level`=0), and all peak registers=0.
REQ-030 SHALL, if reset is asserted mid-frame, discard all partial data, and the first post-reset frame SHALL follow REQ-027.

Configuration
REQ-031 SHALL, with macro EF_I2S_TDM_PEAK_EN defined, provide the following:
- Ports `peak_sel` (in, clog2(NCH)), `peak_clr` (in, 1) and `peak_value` (out, 32).
- Per-slot register peak[k], updated on every capture with `ch_mask`[k]=1 to max(peak[k], |data|), where |data| is the one's-complement magnitude when `sign_extend`=1 and data[31]=1.
- `peak_clr` zeroes all peak registers; a coincident update is discarded.
- `peak_value` = peak[`peak_sel`].
REQ-032 SHALL, without EF_I2S_TDM_PEAK_EN, omit the peak ports and registers entirely, with all other behaviour unchanged.

Structure
REQ-033 SHALL place the slot width constant (32), the ws_mode encodings and the clog2 helper in shared package ef_i2s_pkg.
REQ-034 SHALL instantiate the existing ef_util_fifo with data width 32+clog2(NCH) as its only sub-module; clock generation, framing and capture SHALL be in the top module.

Verification
REQ-035 SHALL cover NCH=4, `sck_prescaler`=1, `left_justified`=0, `ch_mask`=4'hF, slot k driven 32'hA5000000+k: four entries {0..3, 32'hA5000000+k} are read in order, and `sck` period is 4 clk.
REQ-036 SHALL cover `sample_size`=16, `sign_extend`=1, slot word 32'h80010000: `fifo_rdata`=32'hFFFF8001; with `sign_extend`=0 it is 32'h00008001.
REQ-037 SHALL cover `ws_mode`=1, `left_justified`=1: `ws` is high for exactly one SCK period per 128 SCK, and slot 0 MSB is the bit sampled at b=0.
REQ-038 SHALL cover `ch_mask`=4'b0101 with AW=2 and no reads: 4 entries are stored (slots 0,2,0,2), `fifo_full`=1, then the next capture sets `ovr`; `ovr_clr` clears it.
REQ-039 SHALL cover `en` dropped mid-slot 2 and restored, and `rst_n` pulsed mid-frame: no partial word is pushed, and outputs match REQ-026 / REQ-029.
REQ-040 SHALL cover, with EF_I2S_TDM_PEAK_EN defined, slot 1 samples 5, -9, 3 (S=16, signed): peak[1]=8 (one's complement of -9), and after `peak_clr` it is 0.
